// File: rtl/int_ctrl_mc_if.sv
// Register bus between a bus master and the interrupt controller.
interface int_ctrl_mc_if #(
  parameter int ADDRWIDTH = 12
);
  logic [ADDRWIDTH-1:0] addr;
  logic                 read_en;
  logic                 write_en;
  logic [3:0]           byte_strobe;
  logic [31:0]          wdata;
  logic [31:0]          rdata;

  modport master (
    output addr, read_en, write_en, byte_strobe, wdata,
    input  rdata
  );

  modport slave (
    input  addr, read_en, write_en, byte_strobe, wdata,
    output rdata
  );
endinterface

// File: rtl/int_ctrl_mc.sv
// Interrupt controller: per-channel edge/level pending latch, enable mask,
// global enable and a registered lowest-index-first irq request/id.
module int_ctrl_mc #(
  parameter int ADDRWIDTH = 12,
  parameter int NUM_IRQ   = 8
) (
  input  logic               hclk,
  input  logic               hresetn,
  int_ctrl_mc_if.slave       bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,
  output logic [4:0]         irq_id
);

  typedef enum logic [2:0] {
    OFS_PEND   = 3'd0,
    OFS_ENABLE = 3'd1,
    OFS_MODE   = 3'd2,
    OFS_SET    = 3'd3,
    OFS_ACTIVE = 3'd4,
    OFS_CTRL   = 3'd5
  } ofs_e;

  logic [NUM_IRQ-1:0] pend, enable, mode, irq_q;
  logic [NUM_IRQ-1:0] active, hw_set, sw_set, sw_clr, wbits;
  logic               ctrl;
  logic [31:0]        bmask;
  logic [2:0]         widx;
  logic               in_range;
  logic               wr_pend, wr_enable, wr_mode, wr_set, wr_ctrl;
  logic [4:0]         id_next;
  logic               unused;

  assign in_range  = (bus.addr[ADDRWIDTH-1:5] == '0);
  assign widx      = bus.addr[4:2];
  assign wr_pend   = bus.write_en && in_range && (widx == OFS_PEND);
  assign wr_enable = bus.write_en && in_range && (widx == OFS_ENABLE);
  assign wr_mode   = bus.write_en && in_range && (widx == OFS_MODE);
  assign wr_set    = bus.write_en && in_range && (widx == OFS_SET);
  assign wr_ctrl   = bus.write_en && in_range && (widx == OFS_CTRL) && bus.byte_strobe[0];

  assign bmask = {{8{bus.byte_strobe[3]}}, {8{bus.byte_strobe[2]}},
                  {8{bus.byte_strobe[1]}}, {8{bus.byte_strobe[0]}}};
  assign wbits = bus.wdata[NUM_IRQ-1:0] & bmask[NUM_IRQ-1:0];

  // Edge channels only fire on a 0->1 transition of the registered input.
  assign hw_set = irq_in & ~(mode & irq_q);
  assign sw_set = wr_set  ? wbits : '0;
  assign sw_clr = wr_pend ? wbits : '0;
  assign active = pend & enable;

  always_comb begin
    id_next = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (active[i-1]) id_next = 5'(i - 1);
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.read_en && in_range) begin
      case (widx)
        OFS_PEND:   bus.rdata = 32'(pend);
        OFS_ENABLE: bus.rdata = 32'(enable);
        OFS_MODE:   bus.rdata = 32'(mode);
        OFS_ACTIVE: bus.rdata = {irq_out, 26'd0, irq_id};
        OFS_CTRL:   bus.rdata = {31'd0, ctrl};
        default:    bus.rdata = '0;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pend    <= '0;
      enable  <= '0;
      mode    <= '0;
      ctrl    <= 1'b0;
      irq_q   <= '0;
      irq_out <= 1'b0;
      irq_id  <= '0;
    end else begin
      irq_q <= irq_in;
      // Sets are OR'ed after the clear so a same-cycle set always wins.
      pend  <= (pend & ~sw_clr) | hw_set | sw_set;
      if (wr_enable) enable <= (enable & ~bmask[NUM_IRQ-1:0]) | wbits;
      if (wr_mode)   mode   <= (mode   & ~bmask[NUM_IRQ-1:0]) | wbits;
      if (wr_ctrl)   ctrl   <= bus.wdata[0];
      irq_out <= ctrl & (|active);
      irq_id  <= id_next;
    end
  end

  assign unused = ^{bus.addr[1:0], bus.wdata, bmask};

endmodule

// File: tb/tb_int_ctrl_mc.sv
// Bench for int_ctrl_mc: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the register map.
module tb_int_ctrl_mc;
  localparam int AW = 12;
  localparam int N  = 8;

  logic         hclk = 1'b0;
  logic         hresetn = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic         irq_out;
  logic [4:0]   irq_id;

  int_ctrl_mc_if #(.ADDRWIDTH(AW)) bus ();

  int_ctrl_mc #(.ADDRWIDTH(AW), .NUM_IRQ(N)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq_out (irq_out),
    .irq_id  (irq_id)
  );

  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what software would see in each register.
  logic [N-1:0] m_pend, m_en, m_mode, m_prev;
  logic         m_ctrl, m_out;
  logic [4:0]   m_id;

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0;
    m_ctrl = 1'b0; m_out = 1'b0; m_id = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    logic [31:0] v;
    v = '0;
    if (a[AW-1:5] == '0) begin
      case (a[4:2])
        3'd0: v = {24'd0, m_pend};
        3'd1: v = {24'd0, m_en};
        3'd2: v = {24'd0, m_mode};
        3'd4: v = {m_out, 26'd0, m_id};
        3'd5: v = {31'd0, m_ctrl};
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // Advance one clock; model follows the rules using pre-edge inputs/state.
  task automatic step();
    logic [N-1:0] n_pend, n_en, n_mode, act;
    logic         n_ctrl, n_out;
    logic [4:0]   n_id;
    act   = m_pend & m_en;
    n_out = m_ctrl && (act != '0);
    n_id  = '0;
    for (int i = 0; i < N; i++) begin
      if (act[i]) begin n_id = 5'(i); break; end
    end
    n_pend = m_pend; n_en = m_en; n_mode = m_mode; n_ctrl = m_ctrl;
    if (bus.write_en && bus.addr[AW-1:5] == '0 && bus.byte_strobe[0]) begin
      case (bus.addr[4:2])
        3'd0: n_pend = n_pend & ~bus.wdata[N-1:0];
        3'd1: n_en   = bus.wdata[N-1:0];
        3'd2: n_mode = bus.wdata[N-1:0];
        3'd3: n_pend = n_pend | bus.wdata[N-1:0];
        3'd5: n_ctrl = bus.wdata[0];
        default: ;
      endcase
    end
    for (int i = 0; i < N; i++) begin
      if (m_mode[i] ? (irq_in[i] && !m_prev[i]) : irq_in[i]) n_pend[i] = 1'b1;
    end
    @(posedge hclk);
    #1;
    m_pend = n_pend; m_en = n_en; m_mode = n_mode; m_ctrl = n_ctrl;
    m_out = n_out; m_id = n_id; m_prev = irq_in;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.addr = a; bus.wdata = d; bus.byte_strobe = s; bus.write_en = 1'b1;
    step();
    bus.write_en = 1'b0; bus.byte_strobe = 4'h0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
    bus.addr = a; bus.read_en = 1'b1;
    #1;
    d = bus.rdata;
    bus.read_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.addr = '0; bus.wdata = '0; bus.byte_strobe = '0;
    bus.write_en = 1'b0; bus.read_en = 1'b0;
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    model_reset();
    n_cmp++;
    if (irq_out !== 1'b0 || irq_id !== 5'd0) begin
      n_bad++; $display("FAIL reset_outputs got out=%0b id=%0d exp out=0 id=0", irq_out, irq_id);
    end
    for (int r = 0; r < 6; r++) begin
      bus_read(AW'(r * 4), d);
      n_cmp++;
      if (d !== 32'd0) begin
        n_bad++; $display("FAIL reset_reg ofs=0x%0h got 0x%08h exp 0x00000000", r * 4, d);
      end
    end
  endtask

  task automatic test_edge_pulse();
    logic [31:0] d;
    bus_write(12'h004, 32'hFF, 4'hF);
    bus_write(12'h014, 32'h1, 4'hF);
    bus_write(12'h008, 32'hFF, 4'hF);
    irq_in = 8'h08;
    step();
    irq_in = '0;
    step();
    bus_read(12'h000, d);
    n_cmp++;
    if (d !== 32'h08 || irq_out !== 1'b1 || irq_id !== 5'd3) begin
      n_bad++; $display("FAIL edge_pulse got pend=0x%0h out=%0b id=%0d exp pend=0x8 out=1 id=3", d, irq_out, irq_id);
    end
    bus_write(12'h000, 32'h08, 4'h1);
    step();
    n_cmp++;
    if (irq_out !== 1'b0) begin
      n_bad++; $display("FAIL edge_w1c got out=%0b exp 0", irq_out);
    end
  endtask

  task automatic test_level_sticky();
    logic [31:0] d;
    bus_write(12'h008, 32'h00, 4'hF);
    irq_in = 8'h20;
    step();
    bus_write(12'h000, 32'h20, 4'h1);
    bus_read(12'h000, d);
    n_cmp++;
    if (d !== 32'h20) begin
      n_bad++; $display("FAIL level_set_wins got pend=0x%0h exp 0x20", d);
    end
    irq_in = '0;
    step();
    bus_write(12'h000, 32'h20, 4'h1);
    bus_read(12'h000, d);
    n_cmp++;
    if (d !== 32'h00) begin
      n_bad++; $display("FAIL level_clear got pend=0x%0h exp 0x0", d);
    end
  endtask

  task automatic test_priority();
    bus_write(12'h008, 32'hFF, 4'hF);
    irq_in = 8'h44;
    step();
    irq_in = '0;
    step();
    n_cmp++;
    if (irq_id !== 5'd2 || irq_out !== 1'b1) begin
      n_bad++; $display("FAIL prio_low got id=%0d out=%0b exp id=2 out=1", irq_id, irq_out);
    end
    bus_write(12'h000, 32'h04, 4'h1);
    step();
    n_cmp++;
    if (irq_id !== 5'd6) begin
      n_bad++; $display("FAIL prio_next got id=%0d exp 6", irq_id);
    end
    bus_write(12'h000, 32'h40, 4'h1);
  endtask

  task automatic test_masking();
    logic [31:0] d;
    bus_write(12'h004, 32'h00, 4'hF);
    irq_in = 8'h02;
    step();
    irq_in = '0;
    step();
    bus_read(12'h000, d);
    n_cmp++;
    if (d !== 32'h02 || irq_out !== 1'b0) begin
      n_bad++; $display("FAIL mask_latch got pend=0x%0h out=%0b exp pend=0x2 out=0", d, irq_out);
    end
    bus_write(12'h004, 32'h02, 4'h1);
    step();
    n_cmp++;
    if (irq_out !== 1'b1 || irq_id !== 5'd1) begin
      n_bad++; $display("FAIL mask_enable got out=%0b id=%0d exp out=1 id=1", irq_out, irq_id);
    end
    bus_write(12'h014, 32'h0, 4'h1);
    step();
    n_cmp++;
    if (irq_out !== 1'b0) begin
      n_bad++; $display("FAIL mask_ctrl_off got out=%0b exp 0", irq_out);
    end
  endtask

  task automatic test_set_strobe();
    logic [31:0] d;
    bus_write(12'h000, 32'hFF, 4'hF);
    bus_write(12'h00C, 32'h80, 4'h0);
    bus_read(12'h000, d);
    n_cmp++;
    if (d !== 32'h00) begin
      n_bad++; $display("FAIL set_nostrobe got pend=0x%0h exp 0x0", d);
    end
    bus_write(12'h00C, 32'h80, 4'h1);
    bus_read(12'h000, d);
    n_cmp++;
    if (d !== 32'h80) begin
      n_bad++; $display("FAIL set_strobe got pend=0x%0h exp 0x80", d);
    end
    bus_read(12'h00C, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++; $display("FAIL set_reads0 got 0x%0h exp 0x0", d);
    end
    bus_read(12'h020, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++; $display("FAIL unmapped_read got 0x%0h exp 0x0", d);
    end
    bus.addr = 12'h000; bus.read_en = 1'b0;
    #1;
    n_cmp++;
    if (bus.rdata !== 32'h0) begin
      n_bad++; $display("FAIL read_en_low got 0x%0h exp 0x0", bus.rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(12'h004, 32'hFF, 4'hF);
    bus_write(12'h014, 32'h1, 4'hF);
    step();
    n_cmp++;
    if (irq_out !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_out got %0b exp 1", irq_out);
    end
    hresetn = 1'b0;
    #1;
    n_cmp++;
    if (irq_out !== 1'b0) begin
      n_bad++; $display("FAIL reset_async_out got %0b exp 0", irq_out);
    end
    bus.addr = 12'h004; bus.wdata = 32'hFF; bus.byte_strobe = 4'hF; bus.write_en = 1'b1;
    @(posedge hclk);
    #1;
    bus.write_en = 1'b0; bus.byte_strobe = 4'h0;
    hresetn = 1'b1;
    model_reset();
    for (int r = 0; r < 6; r++) begin
      bus_read(AW'(r * 4), d);
      n_cmp++;
      if (d !== 32'd0) begin
        n_bad++; $display("FAIL post_reset_reg ofs=0x%0h got 0x%08h exp 0x0", r * 4, d);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic [AW-1:0] a;
    bus_write(12'h004, 32'hFF, 4'hF);
    bus_write(12'h014, 32'h1, 4'hF);
    for (int c = 0; c < 400; c++) begin
      irq_in = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 5) == 0) begin
        a = AW'($urandom_range(0, 5) * 4);
        bus.addr = a; bus.wdata = $urandom; bus.byte_strobe = 4'($urandom);
        bus.write_en = 1'b1;
      end
      step();
      bus.write_en = 1'b0;
      n_cmp++;
      if (irq_out !== m_out || irq_id !== m_id) begin
        n_bad++; $display("FAIL rand_out cyc=%0d got out=%0b id=%0d exp out=%0b id=%0d", c, irq_out, irq_id, m_out, m_id);
      end
      a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      bus_read(a, d);
      e = model_read(a);
      n_cmp++;
      if (d !== e) begin
        n_bad++; $display("FAIL rand_read cyc=%0d addr=0x%0h got 0x%08h exp 0x%08h", c, a, d, e);
      end
    end
    irq_in = '0;
  endtask

  initial begin
    test_reset();
    test_edge_pulse();
    test_level_sticky();
    test_priority();
    test_masking();
    test_set_strobe();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
